// File: rtl/klp32_pkg.sv
// klp32_pkg: shared types and limits for the data-memory arbiter
package klp32_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;
  typedef enum logic {REQ_CPU, REQ_DBG} req_id_t;
  localparam int MEM_LAT_MAX = 8;
  localparam int STARVE_MAX_LIM = 15;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: CPU-first priority pick with a saturating debug-starvation counter
module arb_starve_ctr
  import klp32_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    arbEn,
  input  logic    cpuReq,
  input  logic    dbgReq,
  output logic    grantValid,
  output req_id_t grantId
);
  localparam int CNT_W = $clog2(STARVE_MAX_LIM + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_MAX);
  logic [CNT_W-1:0] starveCnt;
  logic cpuWins;
  // CPU wins until dbg has lost LIMIT times in a row; a lone CPU request always wins
  always_comb begin
    cpuWins = cpuReq && (starveCnt < LIMIT || !dbgReq);
    grantValid = cpuReq || dbgReq;
    grantId = REQ_DBG;
    if (cpuWins) grantId = REQ_CPU;
  end
  // count consecutive dbg losses, clear once dbg is served
  always_ff @(posedge clk or negedge reset)
    if (!reset) starveCnt <= '0;
    else if (arbEn && grantValid)
      starveCnt <= !cpuWins ? '0 : (dbgReq && starveCnt < LIMIT) ? starveCnt + 1'b1 : starveCnt;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one fixed-latency data memory between the core and the debug port
module dmem_arbiter
  import klp32_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_busy
);
  localparam int LAT_W = $clog2(MEM_LAT_MAX);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
  arb_state_t state, nextState;
  req_id_t grantId, winner;
  logic grantValid, latchWe, lastBeat;
  logic [ADDR_W-1:0] latchAddr;
  logic [DATA_W-1:0] latchWdata;
  logic [LAT_W-1:0] latCnt;

  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) uStarve (
    .clk(clk),
    .reset(reset),
    .arbEn(state == IDLE),
    .cpuReq(cpu_req),
    .dbgReq(dbg_req),
    .grantValid(grantValid),
    .grantId(grantId)
  );

  assign lastBeat = state == WAIT && latCnt == '0;
  assign mem_addr = latchAddr;
  assign mem_wdata = latchWdata;

  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nextState;

  // next-state: one access beat, MEM_LAT wait beats, one response beat
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (grantValid) nextState = ACCESS;
      ACCESS:  nextState = WAIT;
      WAIT:    if (latCnt == '0) nextState = RESP;
      default: nextState = IDLE;
    endcase
  end

  // outputs decoded from state and the latched winner
  always_comb begin
    mem_en = state == ACCESS;
    mem_we = state == ACCESS && latchWe;
    cpu_ready = state == RESP && winner == REQ_CPU;
    dbg_ack = state == RESP && winner == REQ_DBG;
    arb_busy = state != IDLE;
  end

  // latch the winning request so requesters may change fields after completion
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      winner <= REQ_CPU;
      latchWe <= 1'b0;
      latchAddr <= '0;
      latchWdata <= '0;
    end else if (state == IDLE && grantValid) begin
      winner <= grantId;
      latchWe <= grantId == REQ_CPU ? cpu_we : dbg_we;
      latchAddr <= grantId == REQ_CPU ? cpu_addr : dbg_addr;
      latchWdata <= grantId == REQ_CPU ? cpu_wdata : dbg_wdata;
    end

  // memory latency countdown, loaded in the access beat
  always_ff @(posedge clk or negedge reset)
    if (!reset) latCnt <= '0;
    else if (state == ACCESS) latCnt <= LAT_INIT;
    else if (state == WAIT && latCnt != '0) latCnt <= latCnt - 1'b1;

  // capture read data for the winner on the last wait beat; writes leave both untouched
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else if (lastBeat && !latchWe) begin
      if (winner == REQ_CPU) cpu_rdata <= mem_rdata;
      else dbg_rdata <= mem_rdata;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
  localparam int LAT1 = 1;
  localparam int LAT3 = 3;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic cpuReq, cpuWe, dbgReq, dbgWe, cpuReq3, dbgReq3;
  logic [31:0] cpuAddr, cpuWdata, dbgAddr, dbgWdata;
  logic [31:0] cpuRdata1, dbgRdata1, memAddr1, memWdata1, memRdata1;
  logic [31:0] cpuRdata3, dbgRdata3, memAddr3, memWdata3, memRdata3;
  logic cpuReady1, dbgAck1, memEn1, memWe1, busy1;
  logic cpuReady3, dbgAck3, memEn3, memWe3, busy3;
  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  int nChecks = 0;
  int nFails = 0;
  int cyc = 0;
  int due1 = -1;
  int due3 = -1;
  logic [31:0] val1, val3;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT1), .STARVE_MAX(SMAX)) dut1 (
    .clk(clk), .reset(rstN),
    .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_rdata(cpuRdata1), .cpu_ready(cpuReady1),
    .dbg_req(dbgReq), .dbg_we(dbgWe), .dbg_addr(dbgAddr), .dbg_wdata(dbgWdata),
    .dbg_rdata(dbgRdata1), .dbg_ack(dbgAck1),
    .mem_en(memEn1), .mem_we(memWe1), .mem_addr(memAddr1), .mem_wdata(memWdata1),
    .mem_rdata(memRdata1), .arb_busy(busy1)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT3), .STARVE_MAX(SMAX)) dut3 (
    .clk(clk), .reset(rstN),
    .cpu_req(cpuReq3), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_rdata(cpuRdata3), .cpu_ready(cpuReady3),
    .dbg_req(dbgReq3), .dbg_we(dbgWe), .dbg_addr(dbgAddr), .dbg_wdata(dbgWdata),
    .dbg_rdata(dbgRdata3), .dbg_ack(dbgAck3),
    .mem_en(memEn3), .mem_we(memWe3), .mem_addr(memAddr3), .mem_wdata(memWdata3),
    .mem_rdata(memRdata3), .arb_busy(busy3)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // memory model: read data valid only in the cycle MEM_LAT after the strobe, noise otherwise
  always @(negedge clk) begin
    memRdata1 = (cyc == due1) ? val1 : $urandom;
    memRdata3 = (cyc == due3) ? val3 : $urandom;
    if (memEn1) begin
      if (memWe1) mem[memAddr1[9:2]] = memWdata1;
      else begin
        due1 = cyc + LAT1;
        val1 = mem[memAddr1[9:2]];
      end
    end
    if (memEn3) begin
      if (memWe3) mem[memAddr3[9:2]] = memWdata3;
      else begin
        due3 = cyc + LAT3;
        val3 = mem[memAddr3[9:2]];
      end
    end
  end

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut;
    rstN = 1'b0;
    cpuReq = 1'b0;
    dbgReq = 1'b0;
    cpuReq3 = 1'b0;
    repeat (2) nextCycle();
    rstN = 1'b1;
  endtask

  task automatic test_reset;
    rstN = 1'b0;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'h104; cpuWdata = $urandom;
    dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 32'h208; dbgWdata = $urandom;
    cpuReq3 = 1'b1;
    nextCycle();
    @(negedge clk);
    nChecks++;
    if ({cpuRdata1, dbgRdata1, memAddr1, memWdata1, cpuReady1, dbgAck1, memEn1, memWe1, busy1} !== '0) begin
      nFails++;
      $display("FAIL reset_outputs: got %h want 0",
               {cpuRdata1, dbgRdata1, memAddr1, memWdata1, cpuReady1, dbgAck1, memEn1, memWe1, busy1});
    end
    nChecks++;
    if ({cpuRdata3, memAddr3, cpuReady3, memEn3, busy3} !== '0) begin
      nFails++;
      $display("FAIL reset_outputs_lat3: got %h want 0", {cpuRdata3, memAddr3, cpuReady3, memEn3, busy3});
    end
    nextCycle();
    rstN = 1'b1;
    cpuReq3 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      nChecks++;
      if (memEn1 !== (c == 1) || cpuReady1 !== (c == 3) || dbgAck1 !== 1'b0) begin
        nFails++;
        $display("FAIL reset_release_c%0d: en=%b rdy=%b ack=%b want en=%b rdy=%b ack=0",
                 c, memEn1, cpuReady1, dbgAck1, c == 1, c == 3);
      end
      if (c == 1) begin
        nChecks++;
        if (memAddr1 !== 32'h104) begin
          nFails++;
          $display("FAIL reset_first_grant: addr=%h want 00000104", memAddr1);
        end
      end
      nextCycle();
      if (c == 3) begin
        cpuReq = 1'b0;
        dbgReq = 1'b0;
      end
    end
  endtask

  task automatic test_cpu_load;
    resetDut();
    mem[8'h40] = 32'hDEADBEEF;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'h100; cpuWdata = $urandom;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      nChecks++;
      if (memEn1 !== (c == 1) || memWe1 !== 1'b0 || cpuReady1 !== (c == 3) || dbgAck1 !== 1'b0
          || busy1 !== (c >= 1 && c <= 3)) begin
        nFails++;
        $display("FAIL cpu_load_c%0d: en=%b we=%b rdy=%b ack=%b busy=%b", c, memEn1, memWe1, cpuReady1, dbgAck1, busy1);
      end
      if (c == 1) begin
        nChecks++;
        if (memAddr1 !== 32'h100) begin
          nFails++;
          $display("FAIL cpu_load_addr: got %h want 00000100", memAddr1);
        end
      end
      nextCycle();
      if (c == 3) cpuReq = 1'b0;
    end
    nChecks++;
    if (cpuRdata1 !== 32'hDEADBEEF) begin
      nFails++;
      $display("FAIL cpu_load_data: got %h want deadbeef", cpuRdata1);
    end
  endtask

  task automatic test_dbg_write;
    resetDut();
    mem[8'h80] = 32'h0;
    dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = 32'h200; dbgWdata = 32'h12345678;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      nChecks++;
      if (memEn1 !== (c == 1) || memWe1 !== (c == 1) || dbgAck1 !== (c == 3) || cpuReady1 !== 1'b0) begin
        nFails++;
        $display("FAIL dbg_write_c%0d: en=%b we=%b ack=%b rdy=%b", c, memEn1, memWe1, dbgAck1, cpuReady1);
      end
      if (c == 1) begin
        nChecks++;
        if (memAddr1 !== 32'h200 || memWdata1 !== 32'h12345678) begin
          nFails++;
          $display("FAIL dbg_write_bus: addr=%h data=%h want 00000200 12345678", memAddr1, memWdata1);
        end
      end
      nextCycle();
      if (c == 3) dbgReq = 1'b0;
    end
    nChecks++;
    if (dbgRdata1 !== 32'h0 || mem[8'h80] !== 32'h12345678) begin
      nFails++;
      $display("FAIL dbg_write_result: rdata=%h mem=%h want 00000000 12345678", dbgRdata1, mem[8'h80]);
    end
  endtask

  task automatic test_starvation;
    byte expOrder[10];
    byte got;
    int cnt = 0;
    int n = 0;
    int last = -1;
    logic [31:0] want;
    for (int i = 0; i < 10; i++) begin
      if (cnt < SMAX) begin
        expOrder[i] = "C";
        cnt++;
      end else begin
        expOrder[i] = "D";
        cnt = 0;
      end
    end
    resetDut();
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = $urandom & 32'h3FC;
    dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = $urandom & 32'h3FC;
    for (int c = 0; c < 60 && n < 10; c++) begin
      got = 0;
      @(negedge clk);
      if (cpuReady1 || dbgAck1) begin
        got = cpuReady1 ? "C" : "D";
        nChecks++;
        if ((cpuReady1 && dbgAck1) || got != expOrder[n]) begin
          nFails++;
          $display("FAIL starve_grant_%0d: rdy=%b ack=%b want %c", n, cpuReady1, dbgAck1, expOrder[n]);
        end
        if (n > 0) begin
          nChecks++;
          if (c - last != LAT1 + 3) begin
            nFails++;
            $display("FAIL starve_gap_%0d: got %0d want %0d", n, c - last, LAT1 + 3);
          end
        end
        want = cpuReady1 ? mem[cpuAddr[9:2]] : mem[dbgAddr[9:2]];
        nChecks++;
        if ((cpuReady1 ? cpuRdata1 : dbgRdata1) !== want) begin
          nFails++;
          $display("FAIL starve_data_%0d: got %h want %h", n, cpuReady1 ? cpuRdata1 : dbgRdata1, want);
        end
        last = c;
        n++;
      end
      nextCycle();
      if (got == "C") cpuAddr = $urandom & 32'h3FC;
      if (got == "D") dbgAddr = $urandom & 32'h3FC;
    end
    nChecks++;
    if (n != 10) begin
      nFails++;
      $display("FAIL starve_timeout: got %0d pulses want 10", n);
    end
    cpuReq = 1'b0;
    dbgReq = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    v = $urandom;
    resetDut();
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'h3F0;
    mem[8'hFC] = v;
    nextCycle();
    nextCycle();
    #2 rstN = 1'b0;
    #1;
    nChecks++;
    if ({cpuRdata1, dbgRdata1, memAddr1, memWdata1, cpuReady1, dbgAck1, memEn1, memWe1, busy1} !== '0) begin
      nFails++;
      $display("FAIL midreset_outputs: got %h want 0",
               {cpuRdata1, dbgRdata1, memAddr1, memWdata1, cpuReady1, dbgAck1, memEn1, memWe1, busy1});
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      nChecks++;
      if (cpuReady1 !== 1'b0 || busy1 !== 1'b0) begin
        nFails++;
        $display("FAIL midreset_hold_c%0d: rdy=%b busy=%b want 0 0", c, cpuReady1, busy1);
      end
      nextCycle();
    end
    rstN = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      nChecks++;
      if (memEn1 !== (c == 1) || cpuReady1 !== (c == LAT1 + 2)) begin
        nFails++;
        $display("FAIL midreset_restart_c%0d: en=%b rdy=%b", c, memEn1, cpuReady1);
      end
      nextCycle();
      if (c == LAT1 + 2) cpuReq = 1'b0;
    end
    nChecks++;
    if (cpuRdata1 !== v) begin
      nFails++;
      $display("FAIL midreset_data: got %h want %h", cpuRdata1, v);
    end
  endtask

  task automatic test_lat3;
    logic [31:0] v;
    v = $urandom;
    resetDut();
    mem[8'h21] = v;
    cpuReq3 = 1'b1; cpuWe = 1'b0; cpuAddr = 32'h84;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      nChecks++;
      if (memEn3 !== (c == 1) || cpuReady3 !== (c == LAT3 + 2) || busy3 !== (c >= 1 && c <= LAT3 + 2)) begin
        nFails++;
        $display("FAIL lat3_c%0d: en=%b rdy=%b busy=%b", c, memEn3, cpuReady3, busy3);
      end
      nextCycle();
      if (c == LAT3 + 2) cpuReq3 = 1'b0;
    end
    nChecks++;
    if (cpuRdata3 !== v) begin
      nFails++;
      $display("FAIL lat3_data: got %h want %h", cpuRdata3, v);
    end
  endtask

  task automatic test_random;
    bit cpuPend = 0;
    bit dbgPend = 0;
    bit winCpu = 0;
    int freeAt = 0;
    int grantAt = -10;
    int pulseAt = -10;
    int starve = 0;
    logic [31:0] expCpu = 32'h0;
    logic [31:0] expDbg = 32'h0;
    resetDut();
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    for (int c = 0; c < 400; c++) begin
      if (!cpuPend && c < 380 && $urandom_range(0, 1) == 1) begin
        cpuPend = 1; cpuWe = 1'($urandom_range(0, 1)); cpuAddr = $urandom & 32'h3FC; cpuWdata = $urandom;
      end
      if (!dbgPend && c < 380 && $urandom_range(0, 1) == 1) begin
        dbgPend = 1; dbgWe = 1'($urandom_range(0, 1)); dbgAddr = $urandom & 32'h3FC; dbgWdata = $urandom;
      end
      cpuReq = cpuPend;
      dbgReq = dbgPend;
      if (c >= freeAt && (cpuPend || dbgPend)) begin
        winCpu = cpuPend && (starve < SMAX || !dbgPend);
        starve = !winCpu ? 0 : dbgPend ? starve + 1 : starve;
        grantAt = c;
        pulseAt = c + LAT1 + 2;
        freeAt = c + LAT1 + 3;
        if (winCpu) begin
          if (cpuWe) shadow[cpuAddr[9:2]] = cpuWdata;
          else expCpu = shadow[cpuAddr[9:2]];
        end else begin
          if (dbgWe) shadow[dbgAddr[9:2]] = dbgWdata;
          else expDbg = shadow[dbgAddr[9:2]];
        end
      end
      @(negedge clk);
      nChecks++;
      if (cpuReady1 !== (c == pulseAt && winCpu) || dbgAck1 !== (c == pulseAt && !winCpu)
          || memEn1 !== (c == grantAt + 1)) begin
        nFails++;
        $display("FAIL rand_c%0d: rdy=%b ack=%b en=%b want %b %b %b", c, cpuReady1, dbgAck1, memEn1,
                 c == pulseAt && winCpu, c == pulseAt && !winCpu, c == grantAt + 1);
      end
      if (c == grantAt + 1) begin
        nChecks++;
        if (memWe1 !== (winCpu ? cpuWe : dbgWe) || memAddr1 !== (winCpu ? cpuAddr : dbgAddr)
            || (memWe1 && memWdata1 !== (winCpu ? cpuWdata : dbgWdata))) begin
          nFails++;
          $display("FAIL rand_bus_c%0d: we=%b addr=%h data=%h", c, memWe1, memAddr1, memWdata1);
        end
      end
      if (c == pulseAt) begin
        nChecks++;
        if (cpuRdata1 !== expCpu || dbgRdata1 !== expDbg) begin
          nFails++;
          $display("FAIL rand_data_c%0d: cpu=%h dbg=%h want %h %h", c, cpuRdata1, dbgRdata1, expCpu, expDbg);
        end
        if (winCpu) cpuPend = 0;
        else dbgPend = 0;
      end
      nextCycle();
    end
    cpuReq = 1'b0;
    dbgReq = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWdata = '0;
    dbgReq = 1'b0; dbgWe = 1'b0; dbgAddr = '0; dbgWdata = '0;
    cpuReq3 = 1'b0; dbgReq3 = 1'b0;
    test_reset();
    test_cpu_load();
    test_dbg_write();
    test_starvation();
    test_reset_mid();
    test_lat3();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
